// File: rtl/uart_tx_feeder.sv
// Buffered byte source for the UART transmitter: a small FIFO drained by an
// FSM that issues one start pulse per frame and paces itself on the UART's busy flag.
module uart_tx_feeder #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    i_wr_data,
  input  logic          i_wr_en,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  input  logic          i_tx_busy,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_start,
  output logic          o_sending
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [AW:0]   FULL_COUNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE      = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE      = AW'(1);
  localparam logic [7:0]    TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  logic [7:0]    fifo_mem [DEPTH];

  state_t        state_q,    state_d;
  logic [7:0]    to_cnt_q,   to_cnt_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW:0]   count_q,    count_d;
  logic          full_q,     full_d;
  logic          empty_q,    empty_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    tx_data_q,  tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          sending_q,  sending_d;

  logic          push;
  logic          pop;

  // Space is judged on the registered full flag only, so a pop in the same
  // cycle never makes room for a write.
  always_comb begin
    push = i_wr_en && !full_q;
    pop  = (state_q == IDLE) && !empty_q && !i_tx_busy;
  end

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = START;
        end
      end
      START: begin
        to_cnt_d = 8'd0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TIMEOUT_LAST) begin
          // No acknowledge from the transmitter: drop the byte, no retry.
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    overflow_d = i_wr_en && full_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      tx_data_d = fifo_mem[rd_ptr_q];
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    full_d     = (count_d == FULL_COUNT);
    empty_d    = (count_d == '0);
    tx_start_d = (state_d == START);
    sending_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      to_cnt_q   <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      sending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      sending_q  <= sending_d;
    end
  end

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      fifo_mem[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_sending  = sending_q;

endmodule
